sm2c_stream_conv: RTL and testbench

Parametrised streaming converter between sign-magnitude (SM) and two's-complement (2C) formats, selectable per sample. Two-stage registered pipeline with valid/ready handshake on both sides. Flags and counts the two non-bijective cases: SM negative zero, and 2C most-negative value, which has no SM representation. Sits between fixed-point datapath blocks (ADC/sensor front ends in SM, arithmetic cores in 2C).

---
 rtl/sm2c_stream_conv.sv | 108 ++++++++++
 tb/tb_sm2c_stream_conv.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2c_stream_conv.sv
// Sign-magnitude <-> two's-complement stream converter, selectable per sample, flags/counts non-bijective codes.
// Latency 2 cycles, 1 sample/cycle; in_ready follows out_ready combinationally, a full stall holds both stages.
module sm2c_stream_conv #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_negz,
    output logic             out_sat,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] negz_cnt,
    output logic [CNT_W-1:0] sat_cnt
);
    localparam int MW = WIDTH - 1;

    logic             s1_vld;
    logic [WIDTH-1:0] s1_dat;
    logic             s1_negz;
    logic             s1_sat;
    logic             s1_adv;
    logic             s2_adv;
    logic             in_min_pat;
    logic [MW-1:0]    neg_mag;
    logic [WIDTH-1:0] conv_dat;
    logic             out_xfer;

    assign s2_adv     = !out_valid || out_ready;
    assign s1_adv     = !s1_vld || s2_adv;
    assign in_ready   = s1_adv;
    assign in_min_pat = in_data[WIDTH-1] && (in_data[MW-1:0] == '0);
    assign out_xfer   = out_valid && out_ready;

    // Both directions negate the low bits identically; they only differ on the
    // 1000..0 pattern, which the captured flags already distinguish by mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_negz <= 1'b0;
            s1_sat  <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat  <= in_data;
                s1_negz <= in_min_pat && !mode;
                s1_sat  <= in_min_pat && mode;
            end
        end
    end

    assign neg_mag = ~s1_dat[MW-1:0] + MW'(1);

    always_comb begin
        conv_dat = s1_dat;
        if (s1_dat[WIDTH-1]) begin
            if (s1_negz) begin
                conv_dat = '0;
            end else if (s1_sat) begin
                conv_dat = {1'b1, {MW{1'b1}}};
            end else begin
                conv_dat = {1'b1, neg_mag};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_negz  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= conv_dat;
                out_negz <= s1_negz;
                out_sat  <= s1_sat;
            end
        end
    end

    // Counters saturate; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            negz_cnt <= '0;
            sat_cnt  <= '0;
        end else if (clr_cnt) begin
            negz_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            if (out_xfer && out_negz && !(&negz_cnt)) begin
                negz_cnt <= negz_cnt + CNT_W'(1);
            end
            if (out_xfer && out_sat && !(&sat_cnt)) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sm2c_stream_conv.sv
// Directed/table-driven bench for sm2c_stream_conv: negedge monitor with an in-order scoreboard.
module tb_sm2c_stream_conv;
    logic        clk;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_negz;
    logic        out_sat;
    logic        clr_cnt;
    logic [15:0] negz_cnt;
    logic [15:0] sat_cnt;

    sm2c_stream_conv #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_negz(out_negz), .out_sat(out_sat), .clr_cnt(clr_cnt),
        .negz_cnt(negz_cnt), .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [7:0] dout;
        logic       negz;
        logic       sat;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       negz;
        logic       sat;
        int         cyc;
        bit         lat;
    } exp_t;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   rdy_mode = 0;
    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t mon_e;
    bit   stall_prev = 0;
    logic [7:0] prev_data;
    logic prev_negz, prev_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [7:0] sm2c(input logic [7:0] x);
        int v;
        v = x[7] ? -int'(x[6:0]) : int'(x[6:0]);
        return v[7:0];
    endfunction

    function automatic logic [7:0] c2sm(input logic [7:0] x);
        int v;
        int m;
        v = int'($signed(x));
        if (v == -128) return 8'hFF;
        if (v >= 0) return x;
        m = -v;
        return {1'b1, m[6:0]};
    endfunction

    // out_ready: 0 = always high, 1 = pseudo-random, 2 = driven by the test itself
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev)
                check(out_valid && out_data == prev_data && out_negz == prev_negz && out_sat == prev_sat,
                      "stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            if (!out_valid || out_ready)
                check(in_ready == 1'b1, "in_ready_high", in_ready, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_output", out_data, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({out_data, out_negz, out_sat} == {mon_e.dout, mon_e.negz, mon_e.sat},
                          "out_data_flags", {out_data, out_negz, out_sat}, {mon_e.dout, mon_e.negz, mon_e.sat});
                    if (mon_e.lat)
                        check(cyc - mon_e.cyc == 2, "latency", cyc - mon_e.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                cur_exp.cyc = cyc;
                cur_exp.lat = (rdy_mode == 0);
                exp_q.push_back(cur_exp);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_negz  = out_negz;
            prev_sat   = out_sat;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic m, input logic [7:0] d, input logic [7:0] e, input logic en, input logic es);
        int n;
        mode = m;
        in_data = d;
        in_valid = 1'b1;
        cur_exp.dout = e;
        cur_exp.negz = en;
        cur_exp.sat = es;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check(0, "in_ready_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        logic [7:0] v;
        logic [7:0] w;

        tbl[0]  = '{1'b0, 8'h85, 8'hFB, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'hFF, 8'h81, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h80, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h81, 8'hFF, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hFB, 8'h85, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h81, 8'hFF, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h05, 8'h05, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h80, 8'hFF, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'hFF, 8'h81, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0};

        rst = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        check({out_data, out_negz, out_sat} == 10'h0, "reset_out_data", {out_data, out_negz, out_sat}, 0);
        check(negz_cnt == 16'h0 && sat_cnt == 16'h0, "reset_counters", {negz_cnt, sat_cnt}, 0);

        // Full SM->2C sweep at full rate
        for (int c = 0; c < 256; c++) begin
            v = c[7:0];
            send(1'b0, v, sm2c(v), v == 8'h80, 1'b0);
        end
        drain();
        check(negz_cnt == 16'd1, "sweep_negz_cnt", negz_cnt, 1);
        check(sat_cnt == 16'd0, "sweep_sat_cnt", sat_cnt, 0);

        for (int i = 0; i < 14; i++)
            send(tbl[i].mode, tbl[i].din, tbl[i].dout, tbl[i].negz, tbl[i].sat);
        drain();
        check(negz_cnt == 16'd2, "table_negz_cnt", negz_cnt, 2);
        check(sat_cnt == 16'd1, "table_sat_cnt", sat_cnt, 1);

        // Round trip with the mode alternating every sample
        for (int c = 0; c < 256; c++) begin
            v = c[7:0];
            if (v != 8'h80) begin
                w = sm2c(v);
                send(1'b0, v, w, 1'b0, 1'b0);
                send(1'b1, w, v, 1'b0, 1'b0);
            end
        end
        drain();

        rdy_mode = 1;
        for (int i = 1; i <= 16; i++) begin
            v = i[7:0];
            send(1'b0, v, v, 1'b0, 1'b0);
        end
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check(negz_cnt == 16'h0 && sat_cnt == 16'h0, "clr_cnt", {negz_cnt, sat_cnt}, 0);

        for (int i = 0; i < 70000; i++)
            send(1'b0, 8'h80, 8'h00, 1'b1, 1'b0);
        drain();
        check(negz_cnt == 16'hFFFF, "negz_cnt_saturate", negz_cnt, 16'hFFFF);

        // Clear in the same cycle as a flagged output transfer
        rdy_mode = 2;
        out_ready = 1'b0;
        send(1'b0, 8'h80, 8'h00, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b1, "stalled_valid", out_valid, 1);
        out_ready = 1'b1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        rdy_mode = 0;
        check(negz_cnt == 16'h0, "clr_priority", negz_cnt, 0);
        check(exp_q.size() == 0, "clr_xfer_done", exp_q.size(), 0);

        send(1'b0, 8'h80, 8'h00, 1'b1, 1'b0);
        send(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1);
        drain();
        check(negz_cnt == 16'd1 && sat_cnt == 16'd1, "cnt_after_clr", {negz_cnt, sat_cnt}, 32'h0001_0001);

        // Asynchronous reset with two samples in flight
        send(1'b0, 8'h11, 8'h11, 1'b0, 1'b0);
        send(1'b0, 8'h22, 8'h22, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "async_reset_valid", out_valid, 0);
        check(negz_cnt == 16'h0 && sat_cnt == 16'h0, "async_reset_cnt", {negz_cnt, sat_cnt}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 8'h85, 8'hFB, 1'b0, 1'b0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "no_stale_output", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
